// File: rtl/data_wkup_buf.sv
// Single-entry operand buffer between IQ select and execute: captures operands at issue,
// merges fixed-latency wakeup results on their arrival cycle, and hands off via valid/ready.
module data_wkup_buf #(
  parameter int REG_COUNT            = 2,
  parameter int WKUP_COUNT           = 2,
  parameter int DATA_W               = 32,
  parameter int MAX_LAT              = 3,
  parameter int WKUP_LAT [WKUP_COUNT] = '{1, 2}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic [REG_COUNT*DATA_W-1:0]    data_i,
  input  logic [REG_COUNT*WKUP_COUNT-1:0] wkup_hit_i,
  input  logic [WKUP_COUNT*DATA_W-1:0]   wkup_data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [REG_COUNT*DATA_W-1:0]    real_data_o,
  output logic [REG_COUNT-1:0]           pending_o
);

  localparam int CW = $clog2(MAX_LAT + 1);
  localparam int SW = (WKUP_COUNT > 1) ? $clog2(WKUP_COUNT) : 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FULL} state_e;

  for (genvar g = 0; g < WKUP_COUNT; g++) begin : g_lat_chk
    if (WKUP_LAT[g] < 1 || WKUP_LAT[g] > MAX_LAT) begin : g_bad_lat
      $error("data_wkup_buf: WKUP_LAT[%0d]=%0d outside 1..%0d", g, WKUP_LAT[g], MAX_LAT);
    end
  end

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      data_q [REG_COUNT];
  logic [DATA_W-1:0]      data_d [REG_COUNT];
  logic [CW-1:0]          cnt_q  [REG_COUNT];
  logic [CW-1:0]          cnt_d  [REG_COUNT];
  logic [SW-1:0]          src_q  [REG_COUNT];
  logic [SW-1:0]          src_d  [REG_COUNT];
  logic [REG_COUNT-1:0]   pend_q, pend_d;

  logic [REG_COUNT-1:0]   arriving;
  logic [DATA_W-1:0]      wdata [REG_COUNT];
  logic                   held, acc, consume;

  // Output side: same-cycle bypass of the arriving wakeup bus into real_data_o.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    arriving    = '0;
    pending_o   = '0;
    real_data_o = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      wdata[i] = '0;
      for (int j = 0; j < WKUP_COUNT; j++) begin
        if (src_q[i] == SW'(j)) wdata[i] = wkup_data_i[j*DATA_W +: DATA_W];
      end
      arriving[i]  = pend_q[i] && (cnt_q[i] == CW'(1));
      pending_o[i] = pend_q[i] & ~arriving[i];
      real_data_o[i*DATA_W +: DATA_W] = arriving[i] ? wdata[i] : data_q[i];
    end
    held          = (state_q != ST_EMPTY);
    valid_o       = held & ~(|pending_o);
    consume       = valid_o & ready_i;
    issue_ready_o = ~held | consume;
    acc           = issue_valid_i & issue_ready_o;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];
      src_d[i]  = src_q[i];
      if (arriving[i]) begin
        data_d[i] = wdata[i];
        pend_d[i] = 1'b0;
      end else if (pend_q[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end

    if (acc) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        data_d[i] = data_i[i*DATA_W +: DATA_W];
        pend_d[i] = 1'b0;
        cnt_d[i]  = '0;
        src_d[i]  = '0;
        // Descending scan so the lowest set hit bit is the one that sticks.
        for (int j = WKUP_COUNT - 1; j >= 0; j--) begin
          if (wkup_hit_i[i*WKUP_COUNT + j]) begin
            pend_d[i] = 1'b1;
            src_d[i]  = SW'(j);
            cnt_d[i]  = CW'(WKUP_LAT[j]);
          end
        end
      end
      state_d = (|pend_d) ? ST_WAIT : ST_FULL;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end else if (held) begin
      state_d = (|pend_d) ? ST_WAIT : ST_FULL;
    end

    if (flush) begin
      state_d = ST_EMPTY;
      pend_d  = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        data_d[i] = '0;
        cnt_d[i]  = '0;
        src_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pend_q  <= '0;
      // NOTE: the data array is reset because real_data_o must read zero out of reset.
      for (int i = 0; i < REG_COUNT; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
        src_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q <= state_d;
      pend_q  <= pend_d;
      for (int i = 0; i < REG_COUNT; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
        src_q[i]  <= src_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_wkup_buf.sv
// Directed bench for data_wkup_buf: hand-computed operand/valid/handshake values
// checked with immediate assertions. Operand 0 occupies the low bits of each bus.
module tb_data_wkup_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [63:0] data_i;
  logic [3:0]  wkup_hit_i;
  logic [63:0] wkup_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] real_data_o;
  logic [1:0]  pending_o;

  int errors = 0;
  int checks = 0;

  data_wkup_buf dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .data_i       (data_i),
    .wkup_hit_i   (wkup_hit_i),
    .wkup_data_i  (wkup_data_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .real_data_o  (real_data_o),
    .pending_o    (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ops(input logic [31:0] op1, input logic [31:0] op0);
    return {op1, op0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid_i = 1'b0; data_i = '0;
    wkup_hit_i = '0; wkup_data_i = '0; ready_i = 1'b1;
    #2;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_iready", 64'(issue_ready_o), 64'd1);
    check("rst_data", real_data_o, 64'd0);
    check("rst_pend", 64'(pending_o), 64'd0);
    tick(); rst = 1'b0;

    // Case 1: no hits, result one cycle after accept
    issue_valid_i = 1'b1; data_i = ops(32'h22, 32'h11); #1;
    check("c1_iready0", 64'(issue_ready_o), 64'd1);
    check("c1_valid0", 64'(valid_o), 64'd0);
    tick(); issue_valid_i = 1'b0; #1;
    check("c1_valid1", 64'(valid_o), 64'd1);
    check("c1_data1", real_data_o, ops(32'h22, 32'h11));
    check("c1_pend1", 64'(pending_o), 64'd0);
    tick(); #1;
    check("c1_valid2", 64'(valid_o), 64'd0);
    check("c1_iready2", 64'(issue_ready_o), 64'd1);

    // Case 2: op0 <- src0 (lat 1), op1 <- src1 (lat 2)
    issue_valid_i = 1'b1; data_i = ops(32'h2, 32'h1); wkup_hit_i = 4'b1001;
    tick(); issue_valid_i = 1'b0; wkup_hit_i = '0; wkup_data_i = ops(32'h55, 32'hAA); #1;
    check("c2_valid1", 64'(valid_o), 64'd0);
    check("c2_pend1", 64'(pending_o), 64'b10);
    check("c2_data1", real_data_o, ops(32'h2, 32'hAA));
    tick(); wkup_data_i = ops(32'hBB, 32'h77); #1;
    check("c2_valid2", 64'(valid_o), 64'd1);
    check("c2_data2", real_data_o, ops(32'hBB, 32'hAA));
    check("c2_pend2", 64'(pending_o), 64'd0);
    tick(); wkup_data_i = '0; #1;
    check("c2_valid3", 64'(valid_o), 64'd0);

    // Multi-hot hit on op0: lowest source (src0, lat 1) wins
    issue_valid_i = 1'b1; data_i = ops(32'h66, 32'h65); wkup_hit_i = 4'b0011;
    tick(); issue_valid_i = 1'b0; wkup_hit_i = '0; wkup_data_i = ops(32'hC1, 32'hC0); #1;
    check("mh_valid1", 64'(valid_o), 64'd1);
    check("mh_data1", real_data_o, ops(32'h66, 32'hC0));
    tick(); wkup_data_i = '0; #1;
    check("mh_valid2", 64'(valid_o), 64'd0);

    // Case 3: case 2 with execute stalled cycles 2..5
    issue_valid_i = 1'b1; data_i = ops(32'h2, 32'h1); wkup_hit_i = 4'b1001;
    tick(); issue_valid_i = 1'b0; wkup_hit_i = '0; wkup_data_i = ops(32'h55, 32'hAA);
    tick(); ready_i = 1'b0; wkup_data_i = ops(32'hBB, 32'h77); #1;
    check("c3_valid2", 64'(valid_o), 64'd1);
    check("c3_data2", real_data_o, ops(32'hBB, 32'hAA));
    check("c3_iready2", 64'(issue_ready_o), 64'd0);
    for (int c = 3; c <= 5; c++) begin
      tick(); wkup_data_i = {$urandom(), $urandom()}; #1;
      check("c3_data_stall", real_data_o, ops(32'hBB, 32'hAA));
      check("c3_valid_stall", 64'(valid_o), 64'd1);
      check("c3_iready_stall", 64'(issue_ready_o), 64'd0);
    end
    tick(); ready_i = 1'b1; wkup_data_i = {$urandom(), $urandom()}; #1;
    check("c3_data6", real_data_o, ops(32'hBB, 32'hAA));
    check("c3_iready6", 64'(issue_ready_o), 64'd1);
    tick(); wkup_data_i = '0; #1;
    check("c3_valid7", 64'(valid_o), 64'd0);

    // Case 4: back-to-back issue, one result per cycle, no bubble
    for (int k = 0; k < 6; k++) begin
      issue_valid_i = 1'b1; data_i = ops(32'(k + 256), 32'(k)); #1;
      check("c4_iready", 64'(issue_ready_o), 64'd1);
      if (k > 0) begin
        check("c4_valid", 64'(valid_o), 64'd1);
        check("c4_data", real_data_o, ops(32'(k + 255), 32'(k - 1)));
      end
      tick();
    end
    issue_valid_i = 1'b0; #1;
    check("c4_valid_last", 64'(valid_o), 64'd1);
    check("c4_data_last", real_data_o, ops(32'h105, 32'h5));
    tick(); #1;
    check("c4_valid_end", 64'(valid_o), 64'd0);

    // Case 5: flush in WAIT with an issue offered; late src1 data must be dropped
    issue_valid_i = 1'b1; data_i = ops(32'h2, 32'h1); wkup_hit_i = 4'b1001;
    tick(); flush = 1'b1; data_i = ops(32'h33, 32'h44); wkup_hit_i = '0;
    wkup_data_i = ops(32'h55, 32'hAA); #1;
    check("c5_iready1", 64'(issue_ready_o), 64'd0);
    tick(); flush = 1'b0; issue_valid_i = 1'b0; wkup_data_i = ops(32'hBB, 32'h0); #1;
    check("c5_valid2", 64'(valid_o), 64'd0);
    check("c5_pend2", 64'(pending_o), 64'd0);
    check("c5_data2", real_data_o, 64'd0);
    check("c5_iready2", 64'(issue_ready_o), 64'd1);
    tick(); wkup_data_i = '0; #1;
    check("c5_data3", real_data_o, 64'd0);

    // Flush beats a back-to-back accept and consume
    issue_valid_i = 1'b1; data_i = ops(32'h2, 32'h1);
    tick(); data_i = ops(32'h9, 32'h9); flush = 1'b1; #1;
    check("c5b_valid1", 64'(valid_o), 64'd1);
    tick(); flush = 1'b0; issue_valid_i = 1'b0; #1;
    check("c5b_valid2", 64'(valid_o), 64'd0);
    check("c5b_data2", real_data_o, 64'd0);

    // Case 6: async reset mid-WAIT
    issue_valid_i = 1'b1; data_i = ops(32'h2, 32'h1); wkup_hit_i = 4'b1001;
    tick(); issue_valid_i = 1'b0; wkup_hit_i = '0; wkup_data_i = ops(32'h55, 32'hAA); #1;
    check("c6_pend1", 64'(pending_o), 64'b10);
    rst = 1'b1; #1;
    check("c6_rst_valid", 64'(valid_o), 64'd0);
    check("c6_rst_iready", 64'(issue_ready_o), 64'd1);
    check("c6_rst_data", real_data_o, 64'd0);
    check("c6_rst_pend", 64'(pending_o), 64'd0);
    tick(); wkup_data_i = ops(32'hBB, 32'h0); #1;
    check("c6_hold_data", real_data_o, 64'd0);
    rst = 1'b0; wkup_data_i = '0;
    issue_valid_i = 1'b1; data_i = ops(32'h22, 32'h11);
    tick(); issue_valid_i = 1'b0; #1;
    check("c6_valid1", 64'(valid_o), 64'd1);
    check("c6_data1", real_data_o, ops(32'h22, 32'h11));
    tick(); #1;
    check("c6_valid2", 64'(valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
